shiftreg_ctrl: RTL and testbench

SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

---
 rtl/shiftreg_ctrl_pkg.sv | 12 +
 rtl/shiftreg_ctrl_shift_reg_core.sv | 32 +++
 rtl/shiftreg_ctrl.sv | 120 ++++++++++++
 tb/tb_shiftreg_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types and defaults for the shift-register controller.
package shiftreg_ctrl_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/shiftreg_ctrl_shift_reg_core.sv
// Parallel-load bidirectional shift register; reset beats load, load beats shift.
module shift_reg_core
   import shiftreg_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] din,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else if (load) begin
         q_q <= din;
      end else if (shift) begin
         // dir=1 moves bits towards the MSB, dir=0 towards the LSB
         q_q <= dir ? {q_q[WIDTH-2:0], ser_in} : {ser_in, q_q[WIDTH-1:1]};
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shiftreg_ctrl.sv
// Command-driven serialiser: loads a word, shifts it out eff_len times, then pulses done.
module shiftreg_ctrl
   import shiftreg_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_dir,
   input  logic [WIDTH-1:0]           cmd_data,
   input  logic [$clog2(WIDTH+1)-1:0] cmd_len,
   input  logic                       abort,
   input  logic                       ser_in,
   output logic                       ser_out,
   output logic                       shift_en,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           rsp_data
);

   localparam int unsigned LenW = $clog2(WIDTH + 1);
   localparam logic [LenW-1:0] MaxLen = LenW'(WIDTH);
   localparam logic [LenW-1:0] OneLen = LenW'(1);

   state_e          state_q, state_d;
   logic [LenW-1:0] cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic [LenW-1:0] eff_len;
   logic            load, shift;
   logic [WIDTH-1:0] q;

   assign eff_len = (cmd_len > MaxLen) ? MaxLen : cmd_len;

   shift_reg_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .shift  (shift),
      .dir    (dir_q),
      .din    (cmd_data),
      .ser_in (ser_in),
      .q      (q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      load      = 1'b0;
      shift     = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      shift_en  = 1'b0;
      ser_out   = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy      = 1'b0;
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load    = 1'b1;
               cnt_d   = eff_len;
               dir_d   = cmd_dir;
               state_d = (eff_len != '0) ? StShift : StDone;
            end
         end
         StShift: begin
            ser_out = dir_q ? q[WIDTH-1] : q[0];
            // An abort suppresses this edge's shift and leaves the register as-is
            if (abort) begin
               state_d = StIdle;
            end else begin
               shift    = 1'b1;
               shift_en = 1'b1;
               cnt_d    = cnt_q - OneLen;
               if (cnt_q == OneLen) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (reset) begin
         load      = 1'b0;
         shift     = 1'b0;
         cmd_ready = 1'b0;
         busy      = 1'b0;
         done      = 1'b0;
         shift_en  = 1'b0;
         ser_out   = 1'b0;
      end
   end

   assign rsp_data = q;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Scoreboard bench for shiftreg_ctrl at WIDTH=8.
module tb_shiftreg_ctrl;
   import shiftreg_ctrl_pkg::*;

   localparam int W  = 8;
   localparam int LW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset, cmd_valid, cmd_ready, cmd_dir, abort, ser_in;
   logic          ser_out, shift_en, busy, done;
   logic [W-1:0]  cmd_data, rsp_data;
   logic [LW-1:0] cmd_len;

   always #5 clk = ~clk;

   shiftreg_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .ser_in    (ser_in),
      .ser_out   (ser_out),
      .shift_en  (shift_en),
      .busy      (busy),
      .done      (done),
      .rsp_data  (rsp_data)
   );

   int checks = 0;
   int failures = 0;

   logic         exp_bits[$];
   logic [W-1:0] exp_rsp[$];
   logic         obs_bits[$];
   int           n_shift;
   int           done_cyc;
   logic [W-1:0] done_rsp;

   // Reference model: expected serial stream and final word for one command
   function automatic void model(input logic dir, input logic [W-1:0] data, input int len,
                                 input logic sin);
      logic [W-1:0] r;
      int n;
      r = data;
      n = (len > W) ? W : len;
      for (int i = 0; i < n; i++) begin
         if (dir) begin
            exp_bits.push_back(r[W-1]);
            r = {r[W-2:0], sin};
         end else begin
            exp_bits.push_back(r[0]);
            r = {sin, r[W-1:1]};
         end
      end
      exp_rsp.push_back(r);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one command from an idle cycle; returns just after the accepting edge
   task automatic issue(input logic dir, input logic [W-1:0] data, input int len, input logic sin);
      obs_bits.delete();
      n_shift  = 0;
      done_cyc = 0;
      done_rsp = '0;
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_data  = data;
      cmd_len   = LW'(len);
      ser_in    = sin;
      tick();
      cmd_valid = 1'b0;
      cmd_dir   = ~dir;
      cmd_data  = ~data;
      cmd_len   = '1;
   endtask

   // Collect serial output per cycle until done or the cycle budget runs out
   task automatic watch(input int inj_cyc, input bit inj_abort, input int limit);
      for (int c = 1; c <= limit; c++) begin
         abort = inj_abort && (c == inj_cyc);
         #1;
         if (shift_en) begin
            obs_bits.push_back(ser_out);
            n_shift++;
         end
         if (done && done_cyc == 0) begin
            done_cyc = c;
            done_rsp = rsp_data;
         end
         if (done_cyc != 0) break;
         if (c < limit) tick();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_data = '0; cmd_len = '0;
      abort = 1'b0; ser_in = 1'b0;
      repeat (3) tick();
      #1;
      checks++;
      if ({cmd_ready, busy, done, shift_en, ser_out} !== 5'b0 || rsp_data !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h exp=00000/00",
                  {cmd_ready, busy, done, shift_en, ser_out}, rsp_data);
      end
      reset = 1'b0;
      tick();
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_ready got=%b busy=%b exp=1 busy=0", cmd_ready, busy);
      end
   endtask

   task automatic test_left;
      logic e, o;
      model(1'b1, 8'hA5, 8, 1'b0);
      issue(1'b1, 8'hA5, 8, 1'b0);
      watch(0, 1'b0, 20);
      for (int i = 0; exp_bits.size() > 0; i++) begin
         e = exp_bits.pop_front();
         o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL left_ser_out[%0d] got=%b exp=%b", i, o, e);
         end
      end
      checks++;
      if (n_shift !== 8 || done_cyc !== 9) begin
         failures++;
         $display("FAIL left_timing shifts=%0d done_cyc=%0d exp 8/9", n_shift, done_cyc);
      end
      e = 1'b0;
      checks++;
      if (done_rsp !== exp_rsp[0]) begin
         failures++;
         $display("FAIL left_rsp got=%h exp=%h", done_rsp, exp_rsp[0]);
      end
      exp_rsp.delete();
      tick();
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL left_ready_after got=%b done=%b exp=1 done=0", cmd_ready, done);
      end
   endtask

   task automatic test_right;
      logic e, o;
      model(1'b0, 8'hA5, 4, 1'b1);
      issue(1'b0, 8'hA5, 4, 1'b1);
      watch(0, 1'b0, 20);
      for (int i = 0; exp_bits.size() > 0; i++) begin
         e = exp_bits.pop_front();
         o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL right_ser_out[%0d] got=%b exp=%b", i, o, e);
         end
      end
      checks++;
      if (n_shift !== 4 || done_cyc !== 5) begin
         failures++;
         $display("FAIL right_timing shifts=%0d done_cyc=%0d exp 4/5", n_shift, done_cyc);
      end
      checks++;
      if (done_rsp !== exp_rsp[0] || done_rsp !== 8'hFA) begin
         failures++;
         $display("FAIL right_rsp got=%h exp=fa", done_rsp);
      end
      exp_rsp.delete();
      tick();
   endtask

   task automatic test_len_bounds;
      model(1'b1, 8'h3C, 0, 1'b0);
      issue(1'b1, 8'h3C, 0, 1'b0);
      watch(0, 1'b0, 10);
      checks++;
      if (n_shift !== 0 || done_cyc !== 1 || done_rsp !== exp_rsp[0]) begin
         failures++;
         $display("FAIL len0 shifts=%0d done_cyc=%0d rsp=%h exp 0/1/%h",
                  n_shift, done_cyc, done_rsp, exp_rsp[0]);
      end
      exp_rsp.delete();
      tick();
      model(1'b0, 8'h96, 9, 1'b1);
      issue(1'b0, 8'h96, 9, 1'b1);
      watch(0, 1'b0, 20);
      checks++;
      if (n_shift !== 8 || done_cyc !== 9 || done_rsp !== exp_rsp[0]) begin
         failures++;
         $display("FAIL len9 shifts=%0d done_cyc=%0d rsp=%h exp 8/9/%h",
                  n_shift, done_cyc, done_rsp, exp_rsp[0]);
      end
      exp_bits.delete();
      exp_rsp.delete();
      tick();
   endtask

   task automatic test_abort;
      logic e, o;
      model(1'b1, 8'hFF, 8, 1'b0);
      issue(1'b1, 8'hFF, 8, 1'b0);
      watch(3, 1'b1, 3);
      for (int i = 0; i < 2; i++) begin
         e = exp_bits.pop_front();
         o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL abort_ser_out[%0d] got=%b exp=%b", i, o, e);
         end
      end
      exp_bits.delete();
      exp_rsp.delete();
      tick();
      abort = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || done_cyc !== 0) begin
         failures++;
         $display("FAIL abort_state ready=%b busy=%b done=%b done_cyc=%0d exp 1/0/0/0",
                  cmd_ready, busy, done, done_cyc);
      end
      checks++;
      if (rsp_data !== 8'hFC) begin
         failures++;
         $display("FAIL abort_reg got=%h exp=fc", rsp_data);
      end
   endtask

   task automatic test_reset_mid;
      issue(1'b1, 8'h5A, 8, 1'b1);
      watch(0, 1'b0, 4);
      tick();
      reset = 1'b1;
      tick();
      #1;
      checks++;
      if ({cmd_ready, busy, done, shift_en, ser_out} !== 5'b0 || rsp_data !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%b/%h exp=00000/00",
                  {cmd_ready, busy, done, shift_en, ser_out}, rsp_data);
      end
      reset = 1'b0;
      tick();
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ready got=%b busy=%b exp=1 busy=0", cmd_ready, busy);
      end
   endtask

   task automatic test_back_to_back;
      logic e, o;
      logic [W-1:0] obs_rsp[$];
      int n_done = 0, d1 = 0, d2 = 0, acc2 = 0, n_acc = 0;
      model(1'b1, 8'hC3, 2, 1'b1);
      model(1'b0, 8'h81, 3, 1'b1);
      obs_bits.delete();
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_data = 8'hC3; cmd_len = LW'(2); ser_in = 1'b1;
      tick();
      cmd_dir = 1'b0; cmd_data = 8'h81; cmd_len = LW'(3);
      for (int c = 1; c <= 30; c++) begin
         if (acc2 != 0 && c > acc2) cmd_valid = 1'b0;
         #1;
         if (shift_en) obs_bits.push_back(ser_out);
         if (cmd_ready && cmd_valid) begin
            n_acc++;
            if (acc2 == 0) acc2 = c;
         end
         if (done) begin
            n_done++;
            obs_rsp.push_back(rsp_data);
            if (n_done == 1) d1 = c;
            else d2 = c;
         end
         if (n_done == 2) break;
         tick();
      end
      checks++;
      if (d1 !== 3 || acc2 !== d1 + 1 || d2 !== 8 || n_acc !== 1) begin
         failures++;
         $display("FAIL b2b_timing d1=%0d acc2=%0d d2=%0d accepts=%0d exp 3/4/8/1",
                  d1, acc2, d2, n_acc);
      end
      for (int i = 0; exp_bits.size() > 0; i++) begin
         e = exp_bits.pop_front();
         o = (obs_bits.size() > 0) ? obs_bits.pop_front() : 1'bx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL b2b_ser_out[%0d] got=%b exp=%b", i, o, e);
         end
      end
      for (int i = 0; exp_rsp.size() > 0; i++) begin
         e = 1'b0;
         checks++;
         if (obs_rsp.size() == 0 || obs_rsp[0] !== exp_rsp[0]) begin
            failures++;
            $display("FAIL b2b_rsp[%0d] got=%h exp=%h", i,
                     (obs_rsp.size() > 0) ? obs_rsp[0] : 8'hxx, exp_rsp[0]);
         end
         void'(exp_rsp.pop_front());
         if (obs_rsp.size() > 0) void'(obs_rsp.pop_front());
      end
      cmd_valid = 1'b0;
      tick();
      tick();
      #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_no_dup busy=%b ready=%b exp 0/1", busy, cmd_ready);
      end
   endtask

   initial begin
      test_reset();
      test_left();
      test_right();
      test_len_bounds();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

endmodule
